// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   loader_state_e   : frame parser states
//   LOADER_BE_*      : byte-lane enable patterns for the memory write port
//   DEFAULT_*        : default sync marker and memory depth
//   word_byte_addr() : word index -> word-aligned byte address
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_e;

  localparam logic [3:0] LOADER_BE_NONE = 4'b0000;
  localparam logic [3:0] LOADER_BE_WORD = 4'b1111;

  localparam logic [7:0] DEFAULT_SYNC_BYTE      = 8'hA5;
  localparam int         DEFAULT_INST_MEM_DEPTH = 2048;

  function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Bundle of the loader's byte-stream input, control/status and memory write port.
//   master : byte source / supervisor side (drives in_data, in_valid, restart)
//   slave  : loader side (drives in_ready, write port and status flags)
interface inst_mem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        core_hold;
  logic        done;
  logic        error;

  modport master (
    output in_data, in_valid, restart,
    input  in_ready, wr_addr, wr_data, wr_be, core_hold, done, error
  );

  modport slave (
    input  in_data, in_valid, restart,
    output in_ready, wr_addr, wr_data, wr_be, core_hold, done, error
  );
endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words.
//   clk, reset  : clock, asynchronous active-high reset
//   byte_data   : incoming byte, taken when byte_strobe is high
//   clear       : restarts packing at lane 0 (partial lanes dropped)
//   word        : last completed word; holds until the next word completes
//   word_strobe : one-cycle pulse in the cycle after the 4th byte
//   last_lane   : the next accepted byte completes a word
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_strobe,
  output logic        last_lane
);

  logic [1:0]  lane_idx_q, lane_idx_d;
  // Lanes 0..2 are staged separately so the published word stays stable
  // while the next word is being collected.
  logic [23:0] lanes_q, lanes_d;
  logic [31:0] word_q, word_d;
  logic        word_strobe_q, word_strobe_d;

  always_comb begin
    lane_idx_d    = lane_idx_q;
    lanes_d       = lanes_q;
    word_d        = word_q;
    word_strobe_d = 1'b0;
    if (clear) begin
      lane_idx_d = 2'd0;
      lanes_d    = 24'd0;
    end else if (byte_strobe) begin
      case (lane_idx_q)
        2'd0:    lanes_d[7:0]   = byte_data;
        2'd1:    lanes_d[15:8]  = byte_data;
        2'd2:    lanes_d[23:16] = byte_data;
        default: begin
          word_d        = {byte_data, lanes_q};
          word_strobe_d = 1'b1;
        end
      endcase
      lane_idx_d = lane_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_idx_q    <= 2'd0;
      lanes_q       <= 24'd0;
      word_q        <= 32'd0;
      word_strobe_q <= 1'b0;
    end else begin
      lane_idx_q    <= lane_idx_d;
      lanes_q       <= lanes_d;
      word_q        <= word_d;
      word_strobe_q <= word_strobe_d;
    end
  end

  assign word        = word_q;
  assign word_strobe = word_strobe_q;
  assign last_lane   = (lane_idx_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: parses a framed byte stream
// (sync, count lo, count hi, N*4 data bytes LSB first, checksum), writes the
// words to consecutive word addresses from 0 and releases core_hold only once
// the XOR checksum over count and data bytes matches.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : byte stream in, restart, memory write port, status flags
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int         INST_MEM_DEPTH = DEFAULT_INST_MEM_DEPTH,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic             clk,
  input  logic             reset,
  inst_mem_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_W = 17'(INST_MEM_DEPTH);

  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          core_hold_q, core_hold_d;

  logic          in_ready;
  logic          accept;
  logic [15:0]   full_count;
  logic [31:0]   asm_word;
  logic          asm_word_strobe;
  logic          asm_last_lane;

  assign in_ready   = (state_q != DONE) && (state_q != ERR);
  assign accept     = bus.in_valid && in_ready;
  assign full_count = {bus.in_data, count_q[7:0]};

  byte_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .byte_data   (bus.in_data),
    .byte_strobe (accept && (state_q == DATA)),
    .clear       (state_q != DATA),
    .word        (asm_word),
    .word_strobe (asm_word_strobe),
    .last_lane   (asm_last_lane)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (accept && (bus.in_data == SYNC_BYTE)) state_d = CNT_LO;
      end
      CNT_LO: begin
        if (accept) begin
          count_d[7:0] = bus.in_data;
          csum_d       = csum_q ^ bus.in_data;
          state_d      = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_d = full_count;
          csum_d  = csum_q ^ bus.in_data;
          if ({1'b0, full_count} > DEPTH_W) state_d = ERR;
          else if (full_count == 16'd0)     state_d = CHECK;
          else                              state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ bus.in_data;
          // Address is captured with the 4th byte so it lines up with the
          // assembler's word in the following write cycle.
          if (asm_last_lane) begin
            wr_addr_d  = word_byte_addr(word_idx_q);
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (bus.restart) begin
          state_d    = IDLE;
          count_d    = 16'd0;
          word_idx_d = 16'd0;
          csum_d     = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags follow the state being entered so they flip on the same edge.
  always_comb begin
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
    core_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      csum_q      <= 8'd0;
      wr_addr_q   <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      wr_addr_q   <= wr_addr_d;
      done_q      <= done_d;
      error_q     <= error_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wr_be     = asm_word_strobe ? LOADER_BE_WORD : LOADER_BE_NONE;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = asm_word;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.core_hold = core_hold_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: frames are built from word lists,
// expected writes are queued at build time and a negedge monitor pops and
// compares every write the loader issues.
module tb_inst_mem_loader;

  localparam int         DEPTH = 2048;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_mem_loader_if bus ();

  inst_mem_loader #(
    .INST_MEM_DEPTH (DEPTH),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tx_words[$];
  logic [7:0]  tx_bytes[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitor: every nonzero wr_be must match the next queued write.
  always @(negedge clk) begin
    wr_t w;
    if (!reset && bus.wr_be !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_be", 32'(bus.wr_be), 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_be", 32'(bus.wr_be), 32'hF);
        chk("wr_addr", bus.wr_addr, w.addr);
        chk("wr_data", bus.wr_data, w.data);
      end
    end
  end

  // Reference model: frame layout, checksum and expected writes from the
  // frame rules directly.
  task automatic build_frame(input int n, input bit bad, input bit junk,
                             output bit exp_done);
    logic [15:0] n16;
    logic [7:0]  cs;
    logic [31:0] w;
    n16 = 16'(n);
    tx_bytes.delete();
    if (junk) tx_bytes.push_back(8'h3C);
    tx_bytes.push_back(SYNC);
    tx_bytes.push_back(n16[7:0]);
    tx_bytes.push_back(n16[15:8]);
    cs = n16[7:0] ^ n16[15:8];
    exp_done = 1'b0;
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      w = tx_words[i];
      for (int b = 0; b < 4; b++) begin
        tx_bytes.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
      exp_q.push_back({32'(4 * i), w});
    end
    tx_bytes.push_back(bad ? (cs ^ 8'h01) : cs);
    exp_done = !bad;
  endtask

  task automatic send_bytes(input bit gaps, output int cycles);
    int waits;
    cycles = 0;
    foreach (tx_bytes[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
          cycles++;
        end
      end
      bus.in_data  = tx_bytes[i];
      bus.in_valid = 1'b1;
      waits = 0;
      while (!bus.in_ready && waits < 50) begin
        @(posedge clk); #1;
        waits++;
        cycles++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input bit bad,
                           input bit junk, input bit gaps);
    bit exp_done;
    int cycles;
    build_frame(n, bad, junk, exp_done);
    send_bytes(gaps, cycles);
    if (!gaps) chk({tag, "_cycles"}, 32'(cycles), 32'(tx_bytes.size()));
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, "_error"}, 32'(bus.error), 32'(!exp_done));
    chk({tag, "_core_hold"}, 32'(bus.core_hold), 32'(!exp_done));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("frame %s words=%0d bad=%0b done=%0b error=%0b", tag, n, bad,
             bus.done, bus.error);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    chk("restart_done", 32'(bus.done), 32'd0);
    chk("restart_error", 32'(bus.error), 32'd0);
    chk("restart_core_hold", 32'(bus.core_hold), 32'd1);
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic rand_words(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dummy;
    int cycles;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.restart  = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_addr", bus.wr_addr, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_core_hold", 32'(bus.core_hold), 32'd1);
    chk("idle_wr_be", 32'(bus.wr_be), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_error", 32'(bus.error), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word A5 01 00 93 00 A0 00 32
    tx_words.delete();
    tx_words.push_back(32'h00A00093);
    run_frame("single", 1, 1'b0, 1'b0, 1'b0);
    do_restart();

    // Three words back-to-back behind a junk byte
    rand_words(3);
    run_frame("three_junk", 3, 1'b0, 1'b1, 1'b0);
    do_restart();

    // Bad checksum (0x33), then the correct frame after restart
    tx_words.delete();
    tx_words.push_back(32'h00A00093);
    run_frame("bad_csum", 1, 1'b1, 1'b0, 1'b0);
    do_restart();
    run_frame("resend", 1, 1'b0, 1'b0, 1'b0);
    do_restart();

    // Oversize count and zero count
    run_frame("oversize", DEPTH + 1, 1'b0, 1'b0, 1'b0);
    do_restart();
    run_frame("zero", 0, 1'b0, 1'b0, 1'b0);
    do_restart();

    // Reset after byte 2 of word 1: only word 0 is written
    rand_words(2);
    build_frame(2, 1'b0, 1'b0, dummy);
    void'(exp_q.pop_back());
    while (tx_bytes.size() > 9) void'(tx_bytes.pop_back());
    send_bytes(1'b0, cycles);
    reset = 1'b1;
    #1;
    chk("midrst_core_hold", 32'(bus.core_hold), 32'd1);
    chk("midrst_wr_be", 32'(bus.wr_be), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("frame midrst aborted after word 0");
    exp_q.delete();
    rand_words(3);
    run_frame("after_rst", 3, 1'b0, 1'b0, 1'b0);
    do_restart();

    // Randomised frames
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(0, 7);
      rand_words(n);
      run_frame("random", n, 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_restart();
    end

    // Full-depth image: last write at (DEPTH-1)*4
    rand_words(DEPTH);
    run_frame("full_depth", DEPTH, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
